// File: rtl/ext_rx_if.sv
// ext_rx_if: read-side AXI4 master of the external DMA unit.
// Accepts read commands, issues them on AR with a registered handshake,
// forwards R beats to the RX data buffer and releases the TID on the last beat.
// Optional build macro: EXT_RX_ERR_CHECK_EN adds per-TID burst length and
// response checking with a sticky error flag.
module ext_rx_if #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_USER_WIDTH  = 6,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int EXT_ADD_WIDTH   = 29,
  parameter int EXT_OPC_WIDTH   = 12,
  parameter int EXT_TID_WIDTH   = 4,
  parameter int MCHAN_LEN_WIDTH = 15,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [EXT_ADD_WIDTH-1:0]   cmd_add_i,
  input  logic [EXT_OPC_WIDTH-1:0]   cmd_opc_i,
  input  logic [MCHAN_LEN_WIDTH-1:0] cmd_len_i,
  input  logic [EXT_TID_WIDTH-1:0]   cmd_tid_i,
  input  logic                       cmd_bst_i,
  input  logic                       cmd_req_i,
  output logic                       cmd_gnt_o,
  input  logic                       valid_tid_i,
  output logic                       release_tid_o,
  output logic [EXT_TID_WIDTH-1:0]   res_tid_o,
  output logic                       synch_req_o,
  output logic [AXI_DATA_WIDTH-1:0]  rx_data_dat_o,
  output logic [EXT_TID_WIDTH-1:0]   rx_data_tid_o,
  output logic                       rx_data_last_o,
  output logic                       rx_data_req_o,
  input  logic                       rx_data_gnt_i,
  output logic                       axi_master_ar_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]  axi_master_ar_addr_o,
  output logic [2:0]                 axi_master_ar_prot_o,
  output logic [3:0]                 axi_master_ar_region_o,
  output logic [7:0]                 axi_master_ar_len_o,
  output logic [2:0]                 axi_master_ar_size_o,
  output logic [1:0]                 axi_master_ar_burst_o,
  output logic                       axi_master_ar_lock_o,
  output logic [3:0]                 axi_master_ar_cache_o,
  output logic [3:0]                 axi_master_ar_qos_o,
  output logic [AXI_ID_WIDTH-1:0]    axi_master_ar_id_o,
  output logic [AXI_USER_WIDTH-1:0]  axi_master_ar_user_o,
  input  logic                       axi_master_ar_ready_i,
  input  logic                       axi_master_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]  axi_master_r_data_i,
  input  logic [1:0]                 axi_master_r_resp_i,
  input  logic                       axi_master_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]    axi_master_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0]  axi_master_r_user_i,
  output logic                       axi_master_r_ready_o,
  input  logic                       err_clr_i,
  output logic                       err_o,
  output logic [EXT_TID_WIDTH-1:0]   err_tid_o
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {AR_IDLE, AR_REQ} ar_state_e;

  ar_state_e                 state_q, state_d;
  logic [OUT_W-1:0]          outstanding_q;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]                ar_len_q;
  logic [2:0]                ar_size_q;
  logic [1:0]                ar_burst_q;
  logic [AXI_ID_WIDTH-1:0]   ar_id_q;

  logic [7:0]                len_base;
  logic [3:0]                lsb_sum;
  logic [7:0]                ar_len_calc;
  logic                      slot_free;
  logic                      below_max;
  logic                      accept;
  logic                      r_hs;
  logic                      last_hs;
  logic [EXT_TID_WIDTH-1:0]  r_tid;

  // Beat count minus one: an extra beat when the start offset plus the
  // length remainder crosses a 64-bit word boundary.
  assign len_base    = 8'(cmd_len_i >> 3);
  assign lsb_sum     = {1'b0, cmd_add_i[2:0]} + {1'b0, cmd_len_i[2:0]};
  assign ar_len_calc = len_base + {7'd0, lsb_sum[3]};

  assign slot_free = (state_q == AR_IDLE) | ((state_q == AR_REQ) & axi_master_ar_ready_i);
  assign below_max = outstanding_q < OUT_W'(MAX_OUTSTANDING);
  assign accept    = cmd_req_i & valid_tid_i & below_max & slot_free;
  assign cmd_gnt_o = accept;

  assign r_tid   = axi_master_r_id_i[EXT_TID_WIDTH-1:0];
  assign r_hs    = axi_master_r_valid_i & rx_data_gnt_i;
  assign last_hs = r_hs & axi_master_r_last_i;

  // AR FSM next state: hold in AR_REQ while the slave stalls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      AR_IDLE: if (accept) state_d = AR_REQ;
      AR_REQ:  if (axi_master_ar_ready_i) state_d = accept ? AR_REQ : AR_IDLE;
      default: state_d = AR_IDLE;
    endcase
  end

  // State register and AR field registers, loaded only on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= AR_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ar_addr_q  <= AXI_ADDR_WIDTH'(cmd_add_i);
        ar_len_q   <= ar_len_calc;
        ar_size_q  <= 3'd3;
        ar_burst_q <= {1'b0, cmd_bst_i};
        ar_id_q    <= AXI_ID_WIDTH'(cmd_tid_i);
      end
    end
  end

  // Reads in flight: counted from accept until the last beat is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      case ({accept, last_hs})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign axi_master_ar_valid_o  = (state_q == AR_REQ);
  assign axi_master_ar_addr_o   = ar_addr_q;
  assign axi_master_ar_len_o    = ar_len_q;
  assign axi_master_ar_size_o   = ar_size_q;
  assign axi_master_ar_burst_o  = ar_burst_q;
  assign axi_master_ar_id_o     = ar_id_q;
  assign axi_master_ar_prot_o   = '0;
  assign axi_master_ar_region_o = '0;
  assign axi_master_ar_lock_o   = 1'b0;
  assign axi_master_ar_cache_o  = '0;
  assign axi_master_ar_qos_o    = '0;
  assign axi_master_ar_user_o   = '0;

  assign axi_master_r_ready_o = rx_data_gnt_i;
  assign rx_data_req_o        = r_hs;
  assign rx_data_dat_o        = axi_master_r_data_i;
  assign rx_data_last_o       = axi_master_r_last_i;
  assign rx_data_tid_o        = r_tid;
  assign release_tid_o        = last_hs;
  assign res_tid_o            = r_tid;
  assign synch_req_o          = last_hs;

`ifdef EXT_RX_ERR_CHECK_EN
  localparam int NTID = 1 << EXT_TID_WIDTH;

  logic [7:0]               exp_len_q  [NTID];
  logic [7:0]               beat_cnt_q [NTID];
  logic                     err_q;
  logic [EXT_TID_WIDTH-1:0] err_tid_q;
  logic                     new_err;

  // A beat is bad if the burst ends early/late or the slave reports an error.
  always_comb begin
    new_err = 1'b0;
    if (r_hs) begin
      new_err = (axi_master_r_last_i  & (beat_cnt_q[r_tid] != exp_len_q[r_tid])) |
                (!axi_master_r_last_i & (beat_cnt_q[r_tid] == exp_len_q[r_tid])) |
                (axi_master_r_resp_i != 2'b00);
    end
  end

  // Per-TID expected length and running beat count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NTID; i++) begin
        exp_len_q[i]  <= '0;
        beat_cnt_q[i] <= '0;
      end
    end else begin
      if (accept) exp_len_q[cmd_tid_i] <= ar_len_calc;
      if (r_hs) beat_cnt_q[r_tid] <= axi_master_r_last_i ? 8'd0 : beat_cnt_q[r_tid] + 8'd1;
    end
  end

  // Sticky error; the first failing TID is kept, and a new error beats a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q     <= 1'b0;
      err_tid_q <= '0;
    end else if (new_err) begin
      err_q <= 1'b1;
      if (!err_q || err_clr_i) err_tid_q <= r_tid;
    end else if (err_clr_i) begin
      err_q     <= 1'b0;
      err_tid_q <= '0;
    end
  end

  assign err_o     = err_q;
  assign err_tid_o = err_tid_q;

  logic unused_sig;
  assign unused_sig = ^{cmd_opc_i, axi_master_r_user_i, axi_master_r_id_i};
`else
  assign err_o     = 1'b0;
  assign err_tid_o = '0;

  logic unused_sig;
  assign unused_sig = ^{cmd_opc_i, axi_master_r_user_i, axi_master_r_id_i,
                        axi_master_r_resp_i, err_clr_i};
`endif

endmodule

// File: tb/tb_ext_rx_if.sv
// Testbench for ext_rx_if: directed scenarios then random traffic, all
// checked against a transaction-level model (pending AR, in-flight burst queue).
module tb_ext_rx_if;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [28:0] cmd_add_i;
  logic [11:0] cmd_opc_i;
  logic [14:0] cmd_len_i;
  logic [3:0]  cmd_tid_i;
  logic        cmd_bst_i, cmd_req_i, cmd_gnt_o, valid_tid_i;
  logic        release_tid_o, synch_req_o;
  logic [3:0]  res_tid_o, rx_data_tid_o;
  logic [63:0] rx_data_dat_o;
  logic        rx_data_last_o, rx_data_req_o, rx_data_gnt_i;
  logic        ar_valid, ar_lock, ar_ready;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot, ar_size;
  logic [3:0]  ar_region, ar_cache, ar_qos, ar_id;
  logic [7:0]  ar_len;
  logic [1:0]  ar_burst;
  logic [5:0]  ar_user;
  logic        r_valid, r_last, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic [3:0]  r_id;
  logic [5:0]  r_user;
  logic        err_clr_i, err_o;
  logic [3:0]  err_tid_o;

  always #5 clk_i = ~clk_i;

  ext_rx_if dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_add_i(cmd_add_i), .cmd_opc_i(cmd_opc_i), .cmd_len_i(cmd_len_i),
    .cmd_tid_i(cmd_tid_i), .cmd_bst_i(cmd_bst_i), .cmd_req_i(cmd_req_i),
    .cmd_gnt_o(cmd_gnt_o), .valid_tid_i(valid_tid_i),
    .release_tid_o(release_tid_o), .res_tid_o(res_tid_o), .synch_req_o(synch_req_o),
    .rx_data_dat_o(rx_data_dat_o), .rx_data_tid_o(rx_data_tid_o),
    .rx_data_last_o(rx_data_last_o), .rx_data_req_o(rx_data_req_o),
    .rx_data_gnt_i(rx_data_gnt_i),
    .axi_master_ar_valid_o(ar_valid), .axi_master_ar_addr_o(ar_addr),
    .axi_master_ar_prot_o(ar_prot), .axi_master_ar_region_o(ar_region),
    .axi_master_ar_len_o(ar_len), .axi_master_ar_size_o(ar_size),
    .axi_master_ar_burst_o(ar_burst), .axi_master_ar_lock_o(ar_lock),
    .axi_master_ar_cache_o(ar_cache), .axi_master_ar_qos_o(ar_qos),
    .axi_master_ar_id_o(ar_id), .axi_master_ar_user_o(ar_user),
    .axi_master_ar_ready_i(ar_ready),
    .axi_master_r_valid_i(r_valid), .axi_master_r_data_i(r_data),
    .axi_master_r_resp_i(r_resp), .axi_master_r_last_i(r_last),
    .axi_master_r_id_i(r_id), .axi_master_r_user_i(r_user),
    .axi_master_r_ready_o(r_ready),
    .err_clr_i(err_clr_i), .err_o(err_o), .err_tid_o(err_tid_o)
  );

  typedef struct {logic [3:0] tid; int len;} burst_t;

  // reference model state
  bit          pend;
  logic [28:0] p_add;
  logic [7:0]  p_len;
  logic [3:0]  p_tid;
  bit          p_bst;
  int          outs;
  burst_t      rq[$];
  int          beat;
  logic [3:0]  next_tid;
  bit          m_err;
  logic [3:0]  m_etid;

  // stimulus knobs
  bit          s_req, s_vtid, s_ready, s_rv, s_rgnt, s_force_last, s_clr;
  logic [28:0] s_add;
  logic [14:0] s_len;
  bit          s_bst;
  logic [1:0]  s_resp;

  int total = 0;
  int bad   = 0;

  // Number of 64-bit words touched by the byte range, minus one, mod 256.
  function automatic logic [7:0] words_m1(logic [28:0] a, logic [14:0] l);
    int v;
    v = int'(a % 8) + int'(l);
    return 8'((v / 8) % 256);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    bit exp_gnt, hs, rel, bad_beat;
    cmd_req_i     = s_req;
    cmd_add_i     = s_add;
    cmd_len_i     = s_len;
    cmd_tid_i     = next_tid;
    cmd_bst_i     = s_bst;
    cmd_opc_i     = 12'($urandom);
    valid_tid_i   = s_vtid;
    ar_ready      = s_ready;
    rx_data_gnt_i = s_rgnt;
    err_clr_i     = s_clr;
    r_valid       = s_rv && (rq.size() > 0);
    if (rq.size() > 0) begin
      r_id   = rq[0].tid;
      r_last = s_force_last || (beat == rq[0].len);
    end else begin
      r_id   = 4'($urandom);
      r_last = 1'b0;
    end
    r_data = {$urandom, $urandom};
    r_resp = s_resp;
    r_user = 6'($urandom);
    #1;
    exp_gnt = s_req && s_vtid && (outs < 8) && (!pend || s_ready);
    hs      = r_valid && s_rgnt;
    rel     = hs && r_last;
    chk("cmd_gnt", 64'(cmd_gnt_o), 64'(exp_gnt));
    chk("ar_valid", 64'(ar_valid), 64'(pend));
    if (pend) begin
      chk("ar_addr", 64'(ar_addr), 64'(p_add));
      chk("ar_len", 64'(ar_len), 64'(p_len));
      chk("ar_id", 64'(ar_id), 64'(p_tid));
      chk("ar_burst", 64'(ar_burst), 64'(p_bst));
      chk("ar_size", 64'(ar_size), 64'd3);
    end
    chk("ar_const0", 64'({ar_prot, ar_region, ar_lock, ar_cache, ar_qos, ar_user}), 64'd0);
    chk("r_ready", 64'(r_ready), 64'(s_rgnt));
    chk("rx_req", 64'(rx_data_req_o), 64'(hs));
    chk("release", 64'(release_tid_o), 64'(rel));
    chk("synch", 64'(synch_req_o), 64'(rel));
    if (hs) begin
      chk("rx_dat", rx_data_dat_o, r_data);
      chk("rx_tid", 64'(rx_data_tid_o), 64'(rq[0].tid));
      chk("rx_last", 64'(rx_data_last_o), 64'(r_last));
    end
    if (rel) chk("res_tid", 64'(res_tid_o), 64'(rq[0].tid));
    chk("err", 64'(err_o), 64'(m_err));
    chk("err_tid", 64'(err_tid_o), 64'(m_etid));
    @(posedge clk_i);
    if (hs) begin
      bad_beat = (r_last && beat != rq[0].len) || (!r_last && beat == rq[0].len) || (s_resp != 2'b00);
`ifdef EXT_RX_ERR_CHECK_EN
      if (bad_beat) begin
        if (!m_err || s_clr) m_etid = rq[0].tid;
        m_err = 1'b1;
      end else if (s_clr) begin
        m_err  = 1'b0;
        m_etid = '0;
      end
`endif
      if (r_last) begin
        void'(rq.pop_front());
        beat = 0;
        outs--;
      end else begin
        beat++;
      end
    end
`ifdef EXT_RX_ERR_CHECK_EN
    else if (s_clr) begin
      m_err  = 1'b0;
      m_etid = '0;
    end
`endif
    if (pend && s_ready) begin
      rq.push_back('{p_tid, int'(p_len)});
      pend = 1'b0;
    end
    if (exp_gnt) begin
      pend  = 1'b1;
      p_add = s_add;
      p_len = words_m1(s_add, s_len);
      p_tid = next_tid;
      p_bst = s_bst;
      next_tid++;
      outs++;
    end
    @(negedge clk_i);
  endtask

  task automatic model_reset();
    pend = 0; outs = 0; rq.delete(); beat = 0; m_err = 0; m_etid = '0;
  endtask

  task automatic idle_knobs();
    s_req = 0; s_vtid = 1; s_ready = 1; s_rv = 0; s_rgnt = 1;
    s_force_last = 0; s_clr = 0; s_resp = 2'b00; s_bst = 1;
  endtask

  initial begin
    next_tid = '0;
    model_reset();
    idle_knobs();
    s_add = '0; s_len = '0;
    cmd_req_i = 0; cmd_add_i = '0; cmd_opc_i = '0; cmd_len_i = '0; cmd_tid_i = '0;
    cmd_bst_i = 0; valid_tid_i = 0; ar_ready = 0; rx_data_gnt_i = 0; err_clr_i = 0;
    r_valid = 0; r_last = 0; r_data = '0; r_resp = '0; r_id = '0; r_user = '0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_gnt", 64'(cmd_gnt_o), 64'd0);
    chk("rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("rst_ar_fields", 64'({ar_addr, ar_len, ar_size, ar_burst, ar_id}), 64'd0);
    chk("rst_outs", 64'({release_tid_o, synch_req_o, rx_data_req_o, err_o}), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // single beat: add 0x10, len 7
    s_add = 29'h10; s_len = 15'd7; s_req = 1; cycle();
    s_req = 0; cycle(); cycle();
    s_rv = 1; cycle(); s_rv = 0; cycle();

    // unaligned: add 0x5, len 0xF, with backpressure mid-burst
    s_add = 29'h5; s_len = 15'hF; s_req = 1; cycle();
    s_req = 0; cycle();
    s_rv = 1; cycle();
    s_rgnt = 0; repeat (3) cycle();
    s_rgnt = 1; repeat (3) cycle();
    s_rv = 0;

    // AR stall for 5 cycles, then back-to-back accepts
    s_add = 29'h123; s_len = 15'd40; s_req = 1; cycle();
    s_ready = 0; s_add = 29'h77; s_len = 15'd3; repeat (5) cycle();
    s_ready = 1; repeat (2) cycle();
    s_req = 0; cycle();
    s_rv = 1; repeat (20) cycle(); s_rv = 0;

    // outstanding limit: 8 single-beat reads with no R, then release
    s_add = '0; s_len = 15'd7; s_req = 1; repeat (10) cycle();
    s_rv = 1; repeat (3) cycle();
    s_req = 0; repeat (12) cycle();
    s_rv = 0;

`ifdef EXT_RX_ERR_CHECK_EN
    // early last on a two-beat burst, then clear, then SLVERR
    s_add = '0; s_len = 15'd15; s_req = 1; cycle();
    s_req = 0; cycle();
    s_rv = 1; s_force_last = 1; cycle();
    s_rv = 0; s_force_last = 0; cycle();
    s_clr = 1; cycle(); s_clr = 0; cycle();
    s_len = 15'd7; s_req = 1; cycle();
    s_req = 0; cycle();
    s_rv = 1; s_resp = 2'b10; cycle();
    s_rv = 0; s_resp = 2'b00; cycle();
    s_clr = 1; cycle(); s_clr = 0; cycle();
`endif

    // reset while an AR is stalled
    s_add = 29'h40; s_len = 15'd8; s_req = 1; s_ready = 0; cycle();
    s_req = 0; cycle();
    rst_ni = 1'b0;
    #1;
    chk("midrst_ar_valid", 64'(ar_valid), 64'd0);
    chk("midrst_ar_addr", 64'(ar_addr), 64'd0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    s_ready = 1;
    cycle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s_req   = ($urandom % 2) == 0;
      s_vtid  = ($urandom % 8) != 0;
      s_ready = ($urandom % 4) != 0;
      s_rv    = ($urandom % 4) != 0;
      s_rgnt  = ($urandom % 4) != 0;
      s_add   = 29'($urandom);
      s_len   = (($urandom % 16) == 0) ? 15'($urandom) : 15'($urandom_range(0, 80));
      s_bst   = 1'($urandom);
      cycle();
    end

    // drain, bounded
    idle_knobs();
    s_rv = 1;
    for (int i = 0; i < 4000 && (rq.size() > 0 || pend); i++) cycle();
    chk("drain_done", 64'(rq.size()), 64'd0);
    s_rv = 0;
    s_add = 29'h8; s_len = 15'd7; s_req = 1; cycle();
    s_req = 0; repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
